// File: rtl/score_sequencer.sv
// score_sequencer: shares one two-digit BCD incrementer between the left and
// right score registers. Point pulses are queued per player (saturating
// counters), granted round-robin, applied low digit then high digit, and
// the winning score freezes play until clr_score or reset.
module score_sequencer #(
    parameter logic [7:0] WIN_SCORE = 8'h11,
    parameter int unsigned PEND_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pt_left,
    input  logic       pt_right,
    input  logic       clr_score,
    output logic [7:0] score_left,
    output logic [7:0] score_right,
    output logic       busy,
    output logic       game_over,
    output logic       winner
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INC_LO    = 3'd1;
    localparam logic [2:0] INC_HI    = 3'd2;
    localparam logic [2:0] CHECK     = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

    localparam logic [1:0] PEND_SAT = 2'(PEND_MAX);
    localparam logic       SIDE_L   = 1'b0;
    localparam logic       SIDE_R   = 1'b1;

    logic [2:0] state_q,      state_d;
    logic [1:0] pend_l_q,     pend_l_d;
    logic [1:0] pend_r_q,     pend_r_d;
    logic [7:0] score_l_q,    score_l_d;
    logic [7:0] score_r_q,    score_r_d;
    logic       grant_q,      grant_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] lo_q,         lo_d;
    logic       carry_q,      carry_d;
    logic       game_over_q,  game_over_d;
    logic       winner_q,     winner_d;

    logic [7:0] sel_score;
    logic [4:0] lo_inc;
    logic [4:0] hi_inc;
    logic       inc_l, inc_r;
    logic       dec_l, dec_r;

    // One BCD digit plus carry-in; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic cin);
        logic [4:0] s;
        s = {1'b0, d} + {4'b0, cin};
        if (s > 5'd9) begin
            bcd_inc = {1'b1, 4'(s - 5'd10)};
        end else begin
            bcd_inc = s;
        end
    endfunction

    // Pending counter: a grant and a new pulse in the same cycle cancel out.
    function automatic logic [1:0] pend_next(input logic [1:0] q, input logic inc,
                                             input logic dec);
        if (inc && !dec) begin
            pend_next = (q == PEND_SAT) ? q : q + 2'd1;
        end else if (dec && !inc) begin
            pend_next = q - 2'd1;
        end else begin
            pend_next = q;
        end
    endfunction

    assign sel_score = grant_q ? score_r_q : score_l_q;
    assign lo_inc    = bcd_inc(sel_score[3:0], 1'b1);
    assign hi_inc    = bcd_inc(sel_score[7:4], carry_q);

    // Arbitration, digit sequencing and win detection.
    always_comb begin
        state_d      = state_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lo_d         = lo_q;
        carry_d      = carry_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        inc_l        = pt_left  && (state_q != GAME_OVER);
        inc_r        = pt_right && (state_q != GAME_OVER);
        dec_l        = 1'b0;
        dec_r        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_l_q != 2'd0 || pend_r_q != 2'd0) begin
                    if (pend_l_q != 2'd0 && pend_r_q != 2'd0) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = (pend_r_q != 2'd0) ? SIDE_R : SIDE_L;
                    end
                    last_grant_d = grant_d;
                    dec_l        = (grant_d == SIDE_L);
                    dec_r        = (grant_d == SIDE_R);
                    state_d      = INC_LO;
                end
            end
            INC_LO: begin
                lo_d    = lo_inc[3:0];
                carry_d = lo_inc[4];
                state_d = INC_HI;
            end
            INC_HI: begin
                // A tens carry-out means 99 -> 100; hold the score at 99 instead.
                if (!hi_inc[4]) begin
                    if (grant_q == SIDE_R) begin
                        score_r_d = {hi_inc[3:0], lo_q};
                    end else begin
                        score_l_d = {hi_inc[3:0], lo_q};
                    end
                end
                state_d = CHECK;
            end
            CHECK: begin
                if (sel_score == WIN_SCORE) begin
                    game_over_d = 1'b1;
                    winner_d    = grant_q;
                    state_d     = GAME_OVER;
                end else begin
                    state_d = IDLE;
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pend_l_d = pend_next(pend_l_q, inc_l, dec_l);
        pend_r_d = pend_next(pend_r_q, inc_r, dec_r);
        if (state_q == GAME_OVER) begin
            pend_l_d = '0;
            pend_r_d = '0;
        end

        // Match restart overrides everything, including a same-cycle point.
        if (clr_score) begin
            state_d      = IDLE;
            score_l_d    = '0;
            score_r_d    = '0;
            pend_l_d     = '0;
            pend_r_d     = '0;
            game_over_d  = 1'b0;
            winner_d     = 1'b0;
            last_grant_d = SIDE_R;
            grant_d      = SIDE_L;
            lo_d         = '0;
            carry_d      = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            grant_q      <= SIDE_L;
            last_grant_q <= SIDE_R;
            lo_q         <= '0;
            carry_q      <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lo_q         <= lo_d;
            carry_q      <= carry_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign busy        = (state_q != IDLE);
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Testbench for score_sequencer: directed point sequences; expected score
// snapshots are queued by the stimulus and popped by a monitor whenever a
// visible output (a score or game_over) changes.
module tb_score_sequencer;

    typedef struct packed {
        logic [7:0] sl;
        logic [7:0] sr;
        logic       go;
        logic       win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pt_left = 1'b0;
    logic       pt_right = 1'b0;
    logic       clr_score = 1'b0;
    logic [7:0] score_left;
    logic [7:0] score_right;
    logic       busy;
    logic       game_over;
    logic       winner;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];

    // Hand-computed BCD sequence of scores 0..11.
    logic [7:0] bcd_tab [0:11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};

    score_sequencer #(.WIN_SCORE(8'h11), .PEND_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pt_left    (pt_left),
        .pt_right   (pt_right),
        .clr_score  (clr_score),
        .score_left (score_left),
        .score_right(score_right),
        .busy       (busy),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push(input logic [7:0] sl, input logic [7:0] sr, input logic go,
                        input logic win);
        exp_t e;
        e.sl = sl; e.sr = sr; e.go = go; e.win = win;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_left(input int gap);
        @(negedge clk); pt_left = 1'b1;
        @(negedge clk); pt_left = 1'b0;
        cycles(gap);
    endtask

    task automatic pulse_right(input int gap);
        @(negedge clk); pt_right = 1'b1;
        @(negedge clk); pt_right = 1'b0;
        cycles(gap);
    endtask

    task automatic do_clear();
        @(negedge clk); clr_score = 1'b1;
        @(negedge clk); clr_score = 1'b0;
        cycles(2);
    endtask

    // Monitor: any visible output change must match the next queued snapshot.
    logic [7:0] prev_sl = '0;
    logic [7:0] prev_sr = '0;
    logic       prev_go = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (score_left !== prev_sl || score_right !== prev_sr || game_over !== prev_go) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got L=%h R=%h go=%b win=%b expected none",
                         score_left, score_right, game_over, winner);
            end else begin
                e = exp_q.pop_front();
                if (score_left !== e.sl || score_right !== e.sr || game_over !== e.go ||
                    (e.go && winner !== e.win)) begin
                    bad++;
                    $display("FAIL snapshot: got L=%h R=%h go=%b win=%b expected L=%h R=%h go=%b win=%b",
                             score_left, score_right, game_over, winner,
                             e.sl, e.sr, e.go, e.win);
                end
            end
            prev_sl = score_left;
            prev_sr = score_right;
            prev_go = game_over;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;

        cycles(3);
        check("rst_score_left", score_left, 8'h00);
        check("rst_score_right", score_right, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_game_over", {6'b0, game_over, winner}, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        cycles(2);

        // Single left point: latency and busy window.
        push(8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clk); pt_left = 1'b1;
        @(negedge clk); pt_left = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k == 2) check("lat_before_e3", score_left, 8'h00);
            if (k == 3) check("lat_after_e3", score_left, 8'h01);
        end
        check("busy_cycles", 8'(busy_cnt), 8'd3);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();

        // Simultaneous points: left wins the first tie, then right.
        push(8'h01, 8'h00, 1'b0, 1'b0);
        push(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk); pt_left = 1'b1; pt_right = 1'b1;
        @(negedge clk); pt_left = 1'b0; pt_right = 1'b0;
        cycles(10);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();

        // Ten left points: 09 -> 10 carries into the tens digit.
        for (int i = 1; i <= 10; i++) begin
            push(bcd_tab[i], 8'h00, 1'b0, 1'b0);
            pulse_left(5);
        end
        check("bcd_carry", score_left, 8'h10);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();

        // Five right pulses while the left point is in flight: pend_r saturates at 3.
        push(8'h01, 8'h00, 1'b0, 1'b0);
        push(8'h01, 8'h01, 1'b0, 1'b0);
        push(8'h01, 8'h02, 1'b0, 1'b0);
        push(8'h01, 8'h03, 1'b0, 1'b0);
        @(negedge clk); pt_left = 1'b1; pt_right = 1'b1;
        @(negedge clk); pt_left = 1'b0;
        cycles(3);
        @(negedge clk); pt_right = 1'b0;
        cycles(25);
        check("sat_right_total", score_right, 8'h03);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();

        // Left reaches WIN_SCORE; later points are ignored.
        for (int i = 1; i <= 11; i++) begin
            push(bcd_tab[i], 8'h00, 1'b0, 1'b0);
            if (i == 11) push(8'h11, 8'h00, 1'b1, 1'b0);
            pulse_left(5);
        end
        pulse_left(2);
        pulse_right(6);
        check("frozen_left", score_left, 8'h11);
        check("frozen_right", score_right, 8'h00);
        check("game_over_busy", {7'b0, busy}, 8'h01);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();
        cycles(6);
        check("idle_after_clear", {7'b0, busy}, 8'h00);

        // Right reaches WIN_SCORE.
        for (int i = 1; i <= 11; i++) begin
            push(8'h00, bcd_tab[i], 1'b0, 1'b0);
            if (i == 11) push(8'h00, 8'h11, 1'b1, 1'b1);
            pulse_right(5);
        end
        check("right_win_flag", {6'b0, game_over, winner}, 8'h03);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        do_clear();

        // clr_score during INC_HI drops the in-flight point.
        @(negedge clk); pt_left = 1'b1;
        @(negedge clk); pt_left = 1'b0;
        cycles(2);
        clr_score = 1'b1;
        @(negedge clk); clr_score = 1'b0;
        cycles(6);
        check("clr_inc_hi_left", score_left, 8'h00);
        check("clr_inc_hi_busy", {7'b0, busy}, 8'h00);

        // Async reset mid-sequence: no partial write survives.
        push(8'h01, 8'h00, 1'b0, 1'b0);
        pulse_left(5);
        push(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk); pt_right = 1'b1;
        @(negedge clk); pt_right = 1'b0;
        cycles(2);
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cycles(8);
        check("rst_mid_right", score_right, 8'h00);
        check("rst_mid_busy", {7'b0, busy}, 8'h00);

        cycles(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expect: got %0d outstanding expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
